// File: rtl/des_key_schedule.sv
// DES key schedule: loads C/D from PC-1 of the key, rotates per round and
// compresses through PC-2 into a valid/ready stream of 16 round keys.
// Build option: define DES_KS_DECRYPT_EN to honour the decrypt input and
// emit K16..K1 via right rotations; otherwise the order is always K1..K16.

// PC-2 compression: 56-bit CD (input bit k-1 = CD bit k) to 48-bit round key.
module des_pc2 (
  input  logic [55:0] i_cd,
  output logic [47:0] o_k
);
  // Source CD bit (1-based) for each subkey bit 1..48.
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  genvar gi;
  generate
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      // Subkey bit gi+1 sits at o_k[47-gi].
      assign o_k[47-gi] = i_cd[PC2_TAB[gi]-1];
    end
  endgenerate
endmodule

module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        last
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Source key bit (1-based) for each CD bit 1..56.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Bit i set means round i+1 rotates by one place, otherwise by two.
  localparam logic [15:0] ONE_SHIFT = 16'h8103;

  state_t      r_state;
  state_t      w_state_next;
  logic [55:0] r_cd;        // r_cd[55] = CD bit 1; C = r_cd[55:28], D = r_cd[27:0]
  logic [3:0]  r_round;
  logic [55:0] w_pc1;
  logic [55:0] w_cd_rotl;
  logic [55:0] w_cd_step;
  logic [55:0] w_pc2_src;
  logic [55:0] w_pc2_in;
  logic [47:0] w_subkey;
  logic        w_key_hs;
  logic        w_sub_hs;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      // CD bit gi+1 from key bit PC1_TAB[gi]; key bit b lives at key_in[64-b].
      assign w_pc1[55-gi] = key_in[64-PC1_TAB[gi]];
    end
    for (gi = 0; gi < 56; gi++) begin : g_pc2_map
      // PC-2 block expects CD bit k on its input bit k-1.
      assign w_pc2_in[gi] = w_pc2_src[55-gi];
    end
  endgenerate

  // Left rotation of both halves by the current round's shift amount.
  assign w_cd_rotl = ONE_SHIFT[r_round]
                   ? {r_cd[54:28], r_cd[55],    r_cd[26:0], r_cd[27]}
                   : {r_cd[53:28], r_cd[55:54], r_cd[25:0], r_cd[27:26]};

`ifdef DES_KS_DECRYPT_EN
  logic        r_decrypt;
  logic [3:0]  w_rev_idx;
  logic [55:0] w_cd_rotr;

  // Undo the rotation that produced the subkey just emitted.
  assign w_rev_idx = 4'd15 - r_round;
  assign w_cd_rotr = ONE_SHIFT[w_rev_idx]
                   ? {r_cd[28],    r_cd[55:29], r_cd[0],   r_cd[27:1]}
                   : {r_cd[29:28], r_cd[55:30], r_cd[1:0], r_cd[27:2]};

  // Encrypt forms Ki from the rotated value; decrypt starts from C16D16 = C0D0.
  assign w_pc2_src = r_decrypt ? r_cd : w_cd_rotl;
  assign w_cd_step = r_decrypt ? w_cd_rotr : w_cd_rotl;

  // Direction is captured with the key and held for the whole sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_decrypt <= 1'b0;
    end else if (w_key_hs) begin
      r_decrypt <= decrypt;
    end
  end
`else
  logic w_unused_decrypt;

  assign w_unused_decrypt = decrypt;
  assign w_pc2_src        = w_cd_rotl;
  assign w_cd_step        = w_cd_rotl;
`endif

  des_pc2 u_pc2 (
    .i_cd (w_pc2_in),
    .o_k  (w_subkey)
  );

  // Next-state and handshake decode; outputs default to the idle view.
  always_comb begin
    w_state_next = r_state;
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    w_key_hs     = 1'b0;
    w_sub_hs     = 1'b0;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        w_key_hs  = key_valid;
        if (key_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        subkey_valid = 1'b1;
        w_sub_hs     = subkey_ready;
        if (subkey_ready && (r_round == 4'd15)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // C/D and round counter: load on key accept, step on each subkey accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cd    <= '0;
      r_round <= '0;
    end else if (w_key_hs) begin
      r_cd    <= w_pc1;
      r_round <= '0;
    end else if (w_sub_hs) begin
      r_cd    <= w_cd_step;
      r_round <= r_round + 4'd1;
    end
  end

  assign subkey = w_subkey;
  assign round  = r_round;
  assign last   = subkey_valid && (r_round == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic FIPS worked example
// key 0x133457799BBCDFF1 and its known K1..K16 values.
module tb_des_key_schedule;
  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        last;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'hFFFFFFFFFFFFFFFF;
`ifdef DES_KS_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic [47:0] enc_tab [16];

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .last         (last)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] exp_key(input logic dec, input int i);
    return (dec && DEC_EN) ? enc_tab[15-i] : enc_tab[i];
  endfunction

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_in = '0; decrypt = 1'b0; subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (subkey_valid !== 1'b0 || subkey !== 48'h0 || round !== 4'd0 || last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b subkey=%h round=%0d last=%b, required 0/0/0/0",
               subkey_valid, subkey, round, last);
    end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_key_ready: got %b, required 1", key_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: key_ready=%b valid=%b, required 1/0", key_ready, subkey_valid);
    end
    $display("reset done: key_ready=%b subkey_valid=%b", key_ready, subkey_valid);
  endtask

  // Precondition: at a negedge with the DUT idle. Optional stall at stall_round.
  task automatic test_sequence(input logic dec, input int stall_round, input string tag);
    logic [47:0] exp;
    key_valid = 1'b1; key_in = KEY_A; decrypt = dec; subkey_ready = 1'b1;
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s key_ready_before: got %b, required 1", tag, key_ready);
    end
    @(negedge clk);
    key_valid = 1'b0;
    $display("[%s] key %h accepted decrypt=%b", tag, KEY_A, dec);
    for (int i = 0; i < 16; i++) begin
      exp = exp_key(dec, i);
      checks++;
      if (subkey_valid !== 1'b1 || round !== 4'(i) || subkey !== exp ||
          last !== (i == 15) || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s round%0d: valid=%b round=%0d subkey=%h last=%b kr=%b, required 1/%0d/%h/%b/0",
                 tag, i, subkey_valid, round, subkey, last, key_ready, i, exp, (i == 15));
      end
      if (i == stall_round) begin
        subkey_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if (subkey_valid !== 1'b1 || round !== 4'(i) || subkey !== exp || last !== 1'b0) begin
            errors++;
            $display("FAIL %s hold%0d: valid=%b round=%0d subkey=%h, required 1/%0d/%h",
                     tag, s, subkey_valid, round, subkey, i, exp);
          end
          $display("[%s] stall %0d round %0d subkey %h", tag, s, round, subkey);
        end
        subkey_ready = 1'b1;
      end
      $display("[%s] round %0d subkey %h last %b", tag, round, subkey, last);
      @(negedge clk);
    end
    checks++;
    if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || round !== 4'd0 || last !== 1'b0) begin
      errors++;
      $display("FAIL %s end_idle: valid=%b kr=%b round=%0d last=%b, required 0/1/0/0",
               tag, subkey_valid, key_ready, round, last);
    end
  endtask

  task automatic test_encrypt();
    test_sequence(1'b0, -1, "enc");
  endtask

  task automatic test_decrypt();
    test_sequence(1'b1, -1, "dec");
  endtask

  task automatic test_backpressure();
    test_sequence(1'b0, 5, "bp");
  endtask

  task automatic test_back_to_back();
    key_valid = 1'b1; key_in = KEY_A; decrypt = 1'b0; subkey_ready = 1'b1;
    @(negedge clk);
    key_in = KEY_B;   // offered during RUN, must be ignored until IDLE
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (subkey_valid !== 1'b1 || round !== 4'(i) || subkey !== enc_tab[i] || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first round%0d: valid=%b round=%0d subkey=%h kr=%b, required 1/%0d/%h/0",
                 i, subkey_valid, round, subkey, key_ready, i, enc_tab[i]);
      end
      $display("[b2b] round %0d subkey %h", round, subkey);
      @(negedge clk);
    end
    checks++;
    if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: kr=%b valid=%b, required 1/0", key_ready, subkey_valid);
    end
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (subkey_valid !== 1'b1 || round !== 4'(i) || subkey !== 48'hFFFFFFFFFFFF || last !== (i == 15)) begin
        errors++;
        $display("FAIL b2b_second round%0d: valid=%b round=%0d subkey=%h last=%b, required 1/%0d/ffffffffffff/%b",
                 i, subkey_valid, round, subkey, last, i, (i == 15));
      end
      $display("[b2b2] round %0d subkey %h", round, subkey);
      @(negedge clk);
    end
    checks++;
    if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: kr=%b valid=%b, required 1/0", key_ready, subkey_valid);
    end
  endtask

  task automatic test_reset_midrun();
    key_valid = 1'b1; key_in = KEY_A; decrypt = 1'b0; subkey_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("[rst] round %0d subkey %h", round, subkey);
      @(negedge clk);
    end
    checks++;
    if (round !== 4'd8 || subkey !== enc_tab[8] || subkey_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_at_round8: round=%0d subkey=%h valid=%b, required 8/%h/1",
               round, subkey, subkey_valid, enc_tab[8]);
    end
    rst = 1'b1;   // handshake also happens this cycle; reset must win
    @(negedge clk);
    checks++;
    if (subkey_valid !== 1'b0 || round !== 4'd0 || key_ready !== 1'b1 || last !== 1'b0) begin
      errors++;
      $display("FAIL rst_midrun: valid=%b round=%0d kr=%b last=%b, required 0/0/1/0",
               subkey_valid, round, key_ready, last);
    end
    $display("[rst] reset applied at round 8");
    key_valid = 1'b1;   // key offered while rst is high must not be taken
    @(negedge clk);
    checks++;
    if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_priority: valid=%b kr=%b, required 0/1", subkey_valid, key_ready);
    end
    rst = 1'b0; key_valid = 1'b0;
    @(negedge clk);
    test_sequence(1'b0, -1, "after_rst");
  endtask

  initial begin
    enc_tab[0]  = 48'h1B02EFFC7072; enc_tab[1]  = 48'h79AED9DBC9E5;
    enc_tab[2]  = 48'h55FC8A42CF99; enc_tab[3]  = 48'h72ADD6DB351D;
    enc_tab[4]  = 48'h7CEC07EB53A8; enc_tab[5]  = 48'h63A53E507B2F;
    enc_tab[6]  = 48'hEC84B7F618BC; enc_tab[7]  = 48'hF78A3AC13BFB;
    enc_tab[8]  = 48'hE0DBEBEDE781; enc_tab[9]  = 48'hB1F347BA464F;
    enc_tab[10] = 48'h215FD3DED386; enc_tab[11] = 48'h7571F59467E9;
    enc_tab[12] = 48'h97C5D1FABA41; enc_tab[13] = 48'h5F43B7F2E73A;
    enc_tab[14] = 48'hBF918D3D3F0A; enc_tab[15] = 48'hCB3D8B0E17F5;

    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have parameters: none; all widths are fixed by FIPS 46-3.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: key_valid  input  1  64-bit key offered.
REQ-005 SHALL have port: key_in  input  64  DES key; key_in[63] = FIPS bit 1; parity bits ignored.
REQ-006 SHALL have port: decrypt  input  1  sampled with key; 1 = emit K16..K1.
REQ-007 SHALL have port: key_ready  output  1  high only in IDLE.
REQ-008 SHALL have port: subkey  output  48  current round key; subkey[47] = FIPS subkey bit 1.
REQ-009 SHALL have port: subkey_valid  output  1  subkey presented.
REQ-010 SHALL have port: subkey_ready  input  1  consumer accepts subkey.
REQ-011 SHALL have port: round  output  4  index of presented subkey, 0 = K1 … 15 = K16.
REQ-012 SHALL have port: last  output  1  high with the final subkey of the sequence.

Function
REQ-013 SHALL have FSM states IDLE, RUN; reset state IDLE.
REQ-014 Key handshake SHALL occur when key_valid && key_ready. In the same edge, the block SHALL load C/D with PC-1(key_in) and latch decrypt, then enter RUN.
REQ-015 The first subkey SHALL be valid in the cycle after key acceptance (latency 1).
REQ-016 Encrypt order: the block SHALL rotate C and D left by S[i] before forming Ki, with S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 Decrypt order: the first subkey SHALL be PC-2 of the unrotated PC-1 value, which is K16. Each following subkey SHALL be produced by rotating C and D right by S[16-n] (n = subkey index, 1-based, just emitted).
REQ-018 subkey SHALL be formed by instantiating the team PC2 module. Its input bit k-1 carries CD bit k (C = CD bits 1..28).
REQ-019 The sequence SHALL advance only on a subkey handshake (subkey_valid && subkey_ready).
REQ-020 While subkey_valid && !subkey_ready, subkey, round and last SHALL hold stable.
REQ-021 round SHALL count 0..15 and SHALL equal the emitted-subkey count in both modes. In decrypt mode, round 0 carries K16.
REQ-022 last SHALL be high exactly when round == 15 and subkey_valid.
REQ-023 On the handshake with last high, the FSM SHALL return to IDLE. key_ready SHALL rise the next cycle, and round SHALL wrap to 0.
REQ-024 key_valid SHALL be ignored in RUN; key_ready is 0, so there is no overlap or restart.
REQ-025 With continuous subkey_ready, the block SHALL deliver 16 subkeys in 16 consecutive cycles, with 1 idle cycle before the next key.
REQ-026 subkey_ready while subkey_valid is 0 SHALL have no effect.

Reset
REQ-027 While rst is high, the block SHALL be in IDLE with key_ready=1 (from first cycle after rst deasserts), subkey_valid=0, subkey=0, round=0, last=0, and C/D=0.
REQ-028 rst asserted in RUN SHALL abandon the sequence at the next edge with no further subkey_valid. This SHALL hold even if a handshake occurs in that cycle.
REQ-029 rst SHALL take priority over a simultaneous key handshake.

Configuration
REQ-030 With macro DES_KS_DECRYPT_EN defined, the block SHALL implement the decrypt port and the right-rotation path per REQ-017.
REQ-031 Without DES_KS_DECRYPT_EN, the block SHALL ignore decrypt, always emit K1..K16, and contain no right-rotation logic.

Verification
REQ-032 Encrypt: key_in=0x133457799BBCDFF1, decrypt=0, subkey_ready=1 -> K1=0x1B02EFFC7072 at cycle+1 (round 0), K16=0xCB3D8B0E17F5 at round 15 with last=1.
REQ-033 Decrypt (macro on): same key, decrypt=1 -> round 0 subkey 0xCB3D8B0E17F5, round 15 subkey 0x1B02EFFC7072 with last=1, and all 16 values are the encrypt sequence reversed.
REQ-034 Backpressure: subkey_ready low for 3 cycles at round 5 -> subkey/round held for 4 cycles, and the sequence resumes with round 6 value unchanged from REQ-032.
REQ-035 Overlap: key_valid held high with a second key during RUN -> ignored. key_ready=1 the cycle after the last handshake, and the second key is accepted then.
REQ-036 Reset mid-run: rst pulsed at round 8 -> next cycle subkey_valid=0, round=0, key_ready=1. A fresh key then reproduces REQ-032 exactly.
REQ-037 Macro off: decrypt=1 with key 0x133457799BBCDFF1 -> output identical to REQ-032.
